// File: rtl/dec_gray2bin_pipe.sv
// dec_gray2bin_pipe: two-stage registered Gray-to-binary decoder with
// valid/ready handshake on both sides. A step checker flags every accepted
// word that is not a single-bit Gray step from the previously accepted word,
// and a saturating counter tallies the flagged words.
module dec_gray2bin_pipe #(
    parameter int WIDTH = 10,
    parameter int ERRW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] gray_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] bin_o,
    output logic             step_err,
    input  logic             clr,
    output logic [ERRW-1:0]  err_cnt
);

    // Prefix XOR from the MSB down: bin[i] = bin[i+1] ^ g[i].
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Stage registers
    logic             s1_v_q, s1_v_d;
    logic [WIDTH-1:0] s1_gray_q;
    logic             s1_err_q;
    logic             s2_v_q, s2_v_d;
    logic [WIDTH-1:0] s2_bin_q;
    logic             s2_err_q;

    // Checker history and error counter
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             have_prev_q, have_prev_d;
    logic [ERRW-1:0]  err_cnt_q, err_cnt_d;

    // Handshake and checker combinational terms
    logic             s2_adv;
    logic             s1_adv;
    logic             accept;
    logic [WIDTH-1:0] step_diff;
    logic             step_err_in;

    // Advance rules, step check and next-state for checker/counter.
    // NOTE: every signal written here gets a default first so no latch can be inferred.
    always_comb begin
        s2_adv      = !s2_v_q || out_ready;
        s1_adv      = !s1_v_q || s2_adv;
        accept      = in_valid && s1_adv;
        s1_v_d      = s1_adv ? accept : s1_v_q;
        s2_v_d      = s2_adv ? s1_v_q : s2_v_q;

        // clr in the same cycle as an accept makes that word the first one.
        step_diff   = gray_i ^ prev_q;
        step_err_in = have_prev_q && !clr && ($countones(step_diff) != 1);

        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        if (accept) begin
            prev_d      = gray_i;
            have_prev_d = 1'b1;
        end else if (clr) begin
            have_prev_d = 1'b0;
        end

        err_cnt_d = err_cnt_q;
        if (clr) begin
            err_cnt_d = '0;
        end else if (accept && step_err_in && (err_cnt_q != {ERRW{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERRW'(1);
        end
    end

    // Stage 1: capture the Gray word and its step flag on an input transfer.
    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_gray_q <= '0;
            s1_err_q  <= 1'b0;
        end else begin
            s1_v_q <= s1_v_d;
            // NOTE: payload loads only on accept, so an idle (possibly X) gray_i never enters state.
            if (accept) begin
                s1_gray_q <= gray_i;
                s1_err_q  <= step_err_in;
            end
        end
    end

    // Stage 2: decode to binary and hold while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_q   <= 1'b0;
            s2_bin_q <= '0;
            s2_err_q <= 1'b0;
        end else begin
            s2_v_q <= s2_v_d;
            if (s2_adv && s1_v_q) begin
                s2_bin_q <= gray2bin(s1_gray_q);
                s2_err_q <= s1_err_q;
            end
        end
    end

    // Checker history and saturating error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign in_ready  = s1_adv;
    assign out_valid = s2_v_q;
    assign bin_o     = s2_bin_q;
    assign step_err  = s2_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_dec_gray2bin_pipe.sv
// tb_dec_gray2bin_pipe: directed tests for the Gray-to-binary pipeline.
// Inputs change 1 ns after the rising edge; outputs are sampled either at the
// falling edge or 1 ns after the rising edge. Output transfers are logged by a
// falling-edge monitor into a queue that each scenario compares with its
// hand-computed expected words.
module tb_dec_gray2bin_pipe;
    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] gray_i;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] bin_o;
    logic         step_err;
    logic         clr;
    logic [7:0]   err_cnt;

    // Second instance with a 2-bit counter, same stimulus, for saturation.
    logic         in_ready_s;
    logic         out_valid_s;
    logic [W-1:0] bin_s;
    logic         step_err_s;
    logic [1:0]   err_cnt_s;

    int checks   = 0;
    int failures = 0;
    logic [W:0] outq[$];

    always #5 clk = ~clk;

    dec_gray2bin_pipe #(.WIDTH(W), .ERRW(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .gray_i(gray_i), .out_valid(out_valid), .out_ready(out_ready),
        .bin_o(bin_o), .step_err(step_err), .clr(clr), .err_cnt(err_cnt)
    );

    dec_gray2bin_pipe #(.WIDTH(W), .ERRW(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .gray_i(gray_i), .out_valid(out_valid_s), .out_ready(out_ready),
        .bin_o(bin_s), .step_err(step_err_s), .clr(clr), .err_cnt(err_cnt_s)
    );

    // Log every output transfer; inputs are stable from here to the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) outq.push_back({step_err, bin_o});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word (optionally with clr) until accepted, bounded to 20 cycles.
    task automatic send(input logic [W-1:0] g, input logic c);
        bit ok = 0;
        in_valid = 1'b1;
        gray_i   = g;
        clr      = c;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            tick();
        end
        in_valid = 1'b0;
        gray_i   = 'x;
        clr      = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_accept: word %0h not accepted within 20 cycles", g);
        end
    endtask

    task automatic drain(input int n);
        in_valid  = 1'b0;
        gray_i    = 'x;
        out_ready = 1'b1;
        repeat (n) tick();
    endtask

    // Compare one logged output word against {err, bin}.
    task automatic expect_out(input string name, input int idx, input logic e, input logic [W-1:0] b);
        checks++;
        if (idx >= outq.size()) begin
            failures++;
            $display("FAIL %s[%0d]: got no word, expected err=%0b bin=%0h", name, idx, e, b);
        end else if (outq[idx] !== {e, b}) begin
            failures++;
            $display("FAIL %s[%0d]: got err=%0b bin=%0h, expected err=%0b bin=%0h",
                     name, idx, outq[idx][W], outq[idx][W-1:0], e, b);
        end
    endtask

    task automatic expect_count(input string name, input int exp_n);
        checks++;
        if (outq.size() != exp_n) begin
            failures++;
            $display("FAIL %s_count: got %0d words, expected %0d", name, outq.size(), exp_n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; gray_i = 10'h155; out_ready = 1'b1; clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || err_cnt !== 8'd0 || bin_o !== '0 || step_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got ov=%0b cnt=%0d bin=%0h err=%0b, expected 0 0 0 0",
                     out_valid, err_cnt, bin_o, step_err);
        end
        in_valid = 1'b0;
        gray_i   = 'x;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %0b expected 1", in_ready);
        end
        tick();
    endtask

    task automatic test_stream();
        outq.delete();
        out_ready = 1'b1;
        send(10'h000, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stream_latency1: got out_valid=%0b expected 0", out_valid);
        end
        send(10'h001, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || bin_o !== 10'd0) begin
            failures++;
            $display("FAIL stream_latency2: got ov=%0b bin=%0h expected ov=1 bin=0", out_valid, bin_o);
        end
        send(10'h003, 1'b0);
        send(10'h002, 1'b0);
        drain(4);
        expect_count("stream", 4);
        for (int i = 0; i < 4; i++) expect_out("stream", i, 1'b0, W'(i));
        checks++;
        if (err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL stream_err_cnt: got %0d expected 0", err_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] grays [6] = '{10'h006, 10'h007, 10'h005, 10'h004, 10'h00C, 10'h00D};
        logic [W-1:0] held;
        int idx = 0;
        outq.delete();
        for (int c = 0; c < 40; c++) begin
            out_ready = !(c >= 2 && c <= 5);
            in_valid  = (idx < 6);
            gray_i    = (idx < 6) ? grays[idx] : 'x;
            @(negedge clk);
            if (c >= 2 && c <= 5) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_in_ready c=%0d: got %0b expected 0", c, in_ready);
                end
            end
            if (c == 2) held = bin_o;
            if (c == 5) begin
                checks++;
                if (bin_o !== held || out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_hold: got ov=%0b bin=%0h expected ov=1 bin=%0h", out_valid, bin_o, held);
                end
            end
            if (in_valid && in_ready) idx++;
            tick();
        end
        drain(2);
        checks++;
        if (idx != 6) begin
            failures++;
            $display("FAIL bp_accepted: got %0d expected 6", idx);
        end
        expect_count("bp", 6);
        for (int i = 0; i < 6; i++) expect_out("bp", i, 1'b0, W'(i + 4));
    endtask

    task automatic test_step_err();
        outq.delete();
        out_ready = 1'b1;
        send(10'h000, 1'b1);
        send(10'h003, 1'b0);
        send(10'h003, 1'b0);
        checks++;
        if (err_cnt !== 8'd2) begin
            failures++;
            $display("FAIL step_err_cnt: got %0d expected 2", err_cnt);
        end
        send(10'h3FF, 1'b1);
        checks++;
        if (err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL step_clr_cnt: got %0d expected 0", err_cnt);
        end
        drain(4);
        expect_count("step", 4);
        expect_out("step", 0, 1'b0, 10'h000);
        expect_out("step", 1, 1'b1, 10'h002);
        expect_out("step", 2, 1'b1, 10'h002);
        expect_out("step", 3, 1'b0, 10'h2AA);
    endtask

    task automatic test_wrap_sat();
        outq.delete();
        out_ready = 1'b1;
        send(10'h200, 1'b1);
        send(10'h000, 1'b0);
        for (int i = 0; i < 5; i++) send(10'h000, 1'b0);
        drain(4);
        expect_count("wrap", 7);
        expect_out("wrap", 0, 1'b0, 10'h3FF);
        expect_out("wrap", 1, 1'b0, 10'h000);
        for (int i = 2; i < 7; i++) expect_out("wrap", i, 1'b1, 10'h000);
        checks++;
        if (err_cnt !== 8'd5) begin
            failures++;
            $display("FAIL wrap_err_cnt: got %0d expected 5", err_cnt);
        end
        checks++;
        if (err_cnt_s !== 2'd3) begin
            failures++;
            $display("FAIL sat_err_cnt: got %0d expected 3", err_cnt_s);
        end
    endtask

    task automatic test_mid_reset();
        outq.delete();
        out_ready = 1'b0;
        send(10'h001, 1'b0);
        send(10'h003, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL midrst_flush: got ov=%0b cnt=%0d expected 0 0", out_valid, err_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        send(10'h3FF, 1'b0);
        drain(4);
        expect_count("midrst", 1);
        expect_out("midrst", 0, 1'b0, 10'h2AA);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_step_err();
        test_wrap_sat();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
